// File: rtl/my_ram_512_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | my_ram_512_arbiter: two-port round-robin front end for my_ram_512, with a   |
// | zero-fill sweep of all 512 words after reset and on clr.                    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module my_ram_512_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  output logic        busy,
  input  logic        p0_req_valid,
  input  logic        p0_req_write,
  input  logic [8:0]  p0_req_addr,
  input  logic [15:0] p0_req_data,
  output logic        p0_req_ready,
  output logic        p0_rsp_valid,
  output logic [15:0] p0_rsp_data,
  input  logic        p1_req_valid,
  input  logic        p1_req_write,
  input  logic [8:0]  p1_req_addr,
  input  logic [15:0] p1_req_data,
  output logic        p1_req_ready,
  output logic        p1_rsp_valid,
  output logic [15:0] p1_rsp_data,
  output logic [8:0]  ram_addr,
  output logic [15:0] ram_in,
  output logic        ram_load,
  input  logic [15:0] ram_out
);

  localparam logic [0:0] c_st_clear  = 1'b0;
  localparam logic [0:0] c_st_run    = 1'b1;
  localparam logic [8:0] c_last_addr = 9'd511;

  logic [0:0]  state_q, state_d;
  logic [8:0]  clr_cnt_q, clr_cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [15:0] rsp0_data_q, rsp0_data_d;
  logic [15:0] rsp1_data_q, rsp1_data_d;
  logic        gnt0, gnt1;

  always_ff @(posedge clk or negedge reset_n) begin : p_state_reg
    if (!reset_n) begin
      state_q      <= c_st_clear;
      clr_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  always_comb begin : p_next_state
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    last_grant_d = last_grant_q;
    if (state_q == c_st_clear) begin
      clr_cnt_d = clr_cnt_q + 9'd1;
      if (clr_cnt_q == c_last_addr) begin
        state_d = c_st_run;
      end
    end else if (clr) begin
      state_d   = c_st_clear;
      clr_cnt_d = '0;
    end
    if (gnt0) begin
      last_grant_d = 1'b0;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
    end
    // Read data is captured at the grant edge; it holds until the next read.
    rsp0_valid_d = gnt0 & ~p0_req_write;
    rsp1_valid_d = gnt1 & ~p1_req_write;
    rsp0_data_d  = rsp0_valid_d ? ram_out : rsp0_data_q;
    rsp1_data_d  = rsp1_valid_d ? ram_out : rsp1_data_q;
  end

  always_comb begin : p_outputs
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    busy     = 1'b0;
    ram_load = 1'b0;
    ram_addr = '0;
    ram_in   = '0;
    if (state_q == c_st_clear) begin
      busy     = 1'b1;
      ram_load = 1'b1;
      ram_addr = clr_cnt_q;
    end else if (!clr) begin
      // On a tie the port that did not win last time is served.
      if (p0_req_valid && (!p1_req_valid || last_grant_q)) begin
        gnt0 = 1'b1;
      end else if (p1_req_valid) begin
        gnt1 = 1'b1;
      end
      if (gnt0) begin
        ram_addr = p0_req_addr;
        ram_in   = p0_req_data;
        ram_load = p0_req_write;
      end else if (gnt1) begin
        ram_addr = p1_req_addr;
        ram_in   = p1_req_data;
        ram_load = p1_req_write;
      end
    end
  end

  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;
  assign p0_rsp_valid = rsp0_valid_q;
  assign p1_rsp_valid = rsp1_valid_q;
  assign p0_rsp_data  = rsp0_data_q;
  assign p1_rsp_data  = rsp1_data_q;

endmodule
`default_nettype wire

// File: tb/tb_my_ram_512_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_my_ram_512_arbiter: scoreboard bench for my_ram_512_arbiter with a      |
// | behavioural 512x16 RAM attached.                                            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_my_ram_512_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr;
  logic        busy;
  logic        p0_req_valid, p0_req_write, p0_req_ready, p0_rsp_valid;
  logic [8:0]  p0_req_addr;
  logic [15:0] p0_req_data, p0_rsp_data;
  logic        p1_req_valid, p1_req_write, p1_req_ready, p1_rsp_valid;
  logic [8:0]  p1_req_addr;
  logic [15:0] p1_req_data, p1_rsp_data;
  logic [8:0]  ram_addr;
  logic [15:0] ram_in, ram_out;
  logic        ram_load;

  logic [15:0] ram_mem [0:511];
  logic [15:0] sh_mem  [0:511];
  logic [15:0] exp0_q [$];
  logic [15:0] exp1_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int pulses0  = 0;
  int pulses1  = 0;

  always #5 clk = ~clk;

  my_ram_512_arbiter dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .busy(busy),
    .p0_req_valid(p0_req_valid), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_data(p0_req_data),
    .p0_req_ready(p0_req_ready), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
    .p1_req_valid(p1_req_valid), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_data(p1_req_data),
    .p1_req_ready(p1_req_ready), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
    .ram_addr(ram_addr), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
  );

  // RAM: combinational read, write on rising edge
  assign ram_out = ram_mem[ram_addr];
  always @(posedge clk) begin
    if (ram_load) ram_mem[ram_addr] <= ram_in;
  end

  // Scoreboard pop: every response pulse must match the oldest expected read
  always @(negedge clk) begin
    logic [15:0] e;
    if (p0_rsp_valid === 1'b1) begin
      pulses0++;
      n_checks++;
      if (exp0_q.size() == 0) begin
        n_fail++;
        $display("FAIL p0_rsp unexpected: got valid with data %h, required no response", p0_rsp_data);
      end else begin
        e = exp0_q.pop_front();
        if (p0_rsp_data !== e) begin
          n_fail++;
          $display("FAIL p0_rsp_data: got %h, required %h", p0_rsp_data, e);
        end
      end
    end
    if (p1_rsp_valid === 1'b1) begin
      pulses1++;
      n_checks++;
      if (exp1_q.size() == 0) begin
        n_fail++;
        $display("FAIL p1_rsp unexpected: got valid with data %h, required no response", p1_rsp_data);
      end else begin
        e = exp1_q.pop_front();
        if (p1_rsp_data !== e) begin
          n_fail++;
          $display("FAIL p1_rsp_data: got %h, required %h", p1_rsp_data, e);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All tasks are entered and left at a falling edge.
  task automatic do_req(input bit port, input bit wr, input logic [8:0] a, input logic [15:0] d);
    int t;
    logic rdy;
    t = 0;
    if (!port) begin
      p0_req_valid = 1'b1; p0_req_write = wr; p0_req_addr = a; p0_req_data = d;
    end else begin
      p1_req_valid = 1'b1; p1_req_write = wr; p1_req_addr = a; p1_req_data = d;
    end
    #1;
    rdy = port ? p1_req_ready : p0_req_ready;
    while (rdy !== 1'b1 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
      rdy = port ? p1_req_ready : p0_req_ready;
    end
    n_checks++;
    if (rdy !== 1'b1 || t != 0) begin
      n_fail++;
      $display("FAIL req_ready p%0d: got %b after %0d cycles, required 1 in request cycle", port, rdy, t);
    end
    if (rdy === 1'b1) begin
      if (wr) sh_mem[a] = d;
      else if (!port) exp0_q.push_back(sh_mem[a]);
      else exp1_q.push_back(sh_mem[a]);
    end
    @(negedge clk);
    if (!port) p0_req_valid = 1'b0;
    else p1_req_valid = 1'b0;
  endtask

  task automatic measure_sweep(input string tag);
    int cycles;
    int bad;
    cycles = 0;
    bad = 0;
    while (busy === 1'b1 && cycles < 2000) begin
      if (ram_load !== 1'b1 || ram_addr !== cycles[8:0] || ram_in !== 16'h0000) bad++;
      cycles++;
      @(negedge clk);
    end
    for (int i = 0; i < 512; i++) sh_mem[i] = 16'h0000;
    n_checks++;
    if (cycles != 512) begin
      n_fail++;
      $display("FAIL %s sweep_len: got %0d cycles, required 512", tag, cycles);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s sweep_drive: got %0d bad cycles, required 0", tag, bad);
    end
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: got %0d/%0d outstanding, required 0/0", tag, exp0_q.size(), exp1_q.size());
    end
    exp0_q.delete();
    exp1_q.delete();
  endtask

  task automatic test_reset();
    p0_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy=%b rdy=%b%b, required busy=1 rdy=00", busy, p0_req_ready, p1_req_ready);
    end
    n_checks++;
    if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0 || p0_rsp_data !== 16'h0 || p1_rsp_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: got v=%b%b d=%h/%h, required v=00 d=0000/0000", p0_rsp_valid, p1_rsp_valid, p0_rsp_data, p1_rsp_data);
    end
    p0_req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_sweep();
    measure_sweep("post_reset");
    do_req(1'b0, 1'b0, 9'h1FF, 16'h0);
    drain("post_reset");
  endtask

  task automatic test_write_read();
    do_req(1'b0, 1'b1, 9'h005, 16'hBEEF);
    do_req(1'b0, 1'b0, 9'h005, 16'h0);
    do_req(1'b0, 1'b1, 9'h006, 16'h5555);
    n_checks++;
    if (p0_rsp_data !== 16'hBEEF || p0_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_hold: got v=%b d=%h, required v=0 d=beef", p0_rsp_valid, p0_rsp_data);
    end
    drain("write_read");
  endtask

  task automatic test_cross_port();
    do_req(1'b0, 1'b1, 9'h100, 16'h1234);
    do_req(1'b1, 1'b0, 9'h100, 16'h0);
    drain("cross_port");
  endtask

  task automatic test_back_to_back();
    int p0s, p1s, exp_port;
    // p0 then p1 writes leave p1 as the last winner, so p0 wins the first tie
    do_req(1'b0, 1'b1, 9'h010, 16'hA0A0);
    do_req(1'b1, 1'b1, 9'h020, 16'hB1B1);
    p0s = pulses0;
    p1s = pulses1;
    p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = 9'h010;
    p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = 9'h020;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_port = i % 2;
      n_checks++;
      if (p0_req_ready !== (exp_port == 0) || p1_req_ready !== (exp_port == 1)) begin
        n_fail++;
        $display("FAIL contention grant %0d: got rdy=%b%b, required port %0d", i, p0_req_ready, p1_req_ready, exp_port);
      end
      if (exp_port == 0) exp0_q.push_back(sh_mem[9'h010]);
      else exp1_q.push_back(sh_mem[9'h020]);
      @(negedge clk);
    end
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    drain("contention");
    n_checks++;
    if (pulses0 - p0s != 3 || pulses1 - p1s != 3) begin
      n_fail++;
      $display("FAIL contention pulses: got %0d/%0d, required 3/3", pulses0 - p0s, pulses1 - p1s);
    end
  endtask

  task automatic test_clear();
    do_req(1'b0, 1'b1, 9'h0AA, 16'hFFFF);
    clr = 1'b1;
    p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = 9'h0AA;
    #1;
    n_checks++;
    if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_no_grant: got rdy=%b%b, required 00", p0_req_ready, p1_req_ready);
    end
    @(negedge clk);
    clr = 1'b0;
    p1_req_valid = 1'b0;
    measure_sweep("clear");
    // last_grant was p0 before clr and must be untouched, so p1 wins this tie
    p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = 9'h0AB;
    p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = 9'h0AA;
    #1;
    n_checks++;
    if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_last_grant: got rdy=%b%b, required 01", p0_req_ready, p1_req_ready);
    end
    exp1_q.push_back(sh_mem[9'h0AA]);
    @(negedge clk);
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    drain("clear");
  endtask

  task automatic test_reset_mid();
    do_req(1'b0, 1'b0, 9'h005, 16'h0);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (p0_rsp_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rsp_drop: got v=%b busy=%b, required v=0 busy=1", p0_rsp_valid, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    measure_sweep("reset_rsp");
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (300) @(negedge clk);
    p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = 9'h001;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0 || p1_req_ready !== 1'b0 || ram_addr !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_mid_sweep: got busy=%b v=%b%b rdy=%b addr=%h, required 1 00 0 000",
               busy, p0_rsp_valid, p1_rsp_valid, p1_req_ready, ram_addr);
    end
    p1_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    measure_sweep("reset_mid");
    drain("reset_mid");
  endtask

  initial begin
    reset_n = 1'b0;
    clr = 1'b0;
    p0_req_valid = 1'b0; p0_req_write = 1'b0; p0_req_addr = '0; p0_req_data = '0;
    p1_req_valid = 1'b0; p1_req_write = 1'b0; p1_req_addr = '0; p1_req_data = '0;
    test_reset();
    test_sweep();
    test_write_read();
    test_cross_port();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Both readies high together is never legal
  always @(negedge clk) begin
    if (p0_req_ready === 1'b1 && p1_req_ready === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL dual_ready: got rdy=11, required at most one");
    end
  end

endmodule
`default_nettype wire
